hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Backward-direction control for the pipeline registers (if_id, id_rr, rr_ex, ex_mem).
- Consumes the hazard-relevant fields that rr_ex presents to EX, plus the RR-stage source IDs.
- Returns per-register enables, flushes and a bubble request to the pipeline registers, and a PC redirect to fetch.
- Handles load-use stalls, including multi-cycle stalls for slow memory, and taken-branch flushes. Keeps saturating stall and flush event counters.

Parameters:
- STALL_CYCLES, 1: stall length in cycles for one load-use hazard; legal range 1..7.
- CNT_W, 16: width of the stall and flush event counters.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- rr_valid  in  1  RR stage holds a real instruction.
- rr_src1  in  3  RR source register 1.
- rr_src2  in  3  RR source register 2.
- rr_use1  in  1  RR instruction reads rr_src1.
- rr_use2  in  1  RR instruction reads rr_src2.
- ex_valid  in  1  EX stage holds a real instruction (not a bubble).
- ex_dest  in  3  EX destination register (m2_out_ex).
- ex_wr_en  in  1  EX instruction writes the register file.
- ex_is_load  in  1  EX instruction is a load.
- ex_br_taken  in  1  EX resolved a taken branch or jump.
- ex_br_target  in  16  redirect address.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  if_id register load enable.
- id_rr_en  out  1  id_rr register load enable.
- rr_ex_bubble  out  1  rr_ex loads a NOP (all write enables 0) instead of RR contents.
- flush_if_id  out  1  clear if_id to NOP.
- flush_id_rr  out  1  clear id_rr to NOP.
- redirect_valid  out  1  PC loads redirect_pc.
- redirect_pc  out  16  branch target.
- stall_cnt  out  CNT_W  load-use events, saturating.
- flush_cnt  out  CNT_W  taken-branch flushes, saturating.

Behaviour:
- Hazard condition lu_hit is combinational:
  - lu_hit = ex_valid & ex_is_load & ex_wr_en & rr_valid & ((rr_use1 & rr_src1==ex_dest) | (rr_use2 & rr_src2==ex_dest)).
  - Register 0 is not special; a match on 0 is a hazard.
- States: RUN and STALL. A 3-bit down-counter stall_left is used only in STALL.
- All outputs are Mealy, combinational from state and inputs, so they take effect in the same cycle the condition is seen.
- RUN with no event:
  - pc_en, if_id_en and id_rr_en are 1.
  - rr_ex_bubble, both flushes and redirect_valid are 0.
- RUN with lu_hit and no ex_br_taken:
  - pc_en, if_id_en and id_rr_en are 0; rr_ex_bubble is 1.
  - stall_cnt increments.
  - If STALL_CYCLES>1, go to STALL with stall_left = STALL_CYCLES-1. Otherwise stay in RUN.
- STALL:
  - Same outputs as the RUN lu_hit cycle. lu_hit is ignored and stall_cnt does not increment.
  - stall_left decrements each cycle. When stall_left==1, return to RUN next cycle.
- ex_br_taken in any state has priority over lu_hit and over STALL:
  - redirect_valid=1, redirect_pc=ex_br_target.
  - flush_if_id=1, flush_id_rr=1, rr_ex_bubble=1.
  - pc_en=1; if_id_en and id_rr_en are don't-care (flush wins).
  - flush_cnt increments. State goes to RUN and stall_left clears to 0.
  - The stalled RR instruction is wrong-path and is discarded by the flush.
- ex_br_taken and lu_hit in the same cycle: only flush_cnt increments.
- Both counters saturate at all-ones and hold there; they never wrap.
- redirect_pc equals ex_br_target whenever redirect_valid=1. Its value at other times is don't-care, but it must be driven and free of X after reset.
- Reset (asynchronous, any time, including mid-stall):
  - state=RUN, stall_left=0, stall_cnt=0, flush_cnt=0.
  - While rst=1, outputs are pc_en=0, if_id_en=0, id_rr_en=0, rr_ex_bubble=1, flush_if_id=1, flush_id_rr=1, redirect_valid=0, redirect_pc=0.
  - The first cycle after deassertion behaves as RUN.

Decomposition:
- Shared pipeline package holds:
  - state encoding: RUN=1'b0, STALL=1'b1;
  - REG_ID_W=3;
  - PC_W=16;
  - NOP-control constants used by the bubble and flush logic in the pipeline registers.
- One natural sub-module, sat_counter (parameter W, inputs inc and clr), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset mid-stall, STALL_CYCLES=3: assert rst during cycle 2 of a stall -> state RUN, counters 0, and the next cycle pc_en=1 with no bubble.
- Load-use hit, STALL_CYCLES=1: ex_dest=3, load, rr_src1=3, rr_use1=1 -> exactly 1 cycle with pc_en=0 and rr_ex_bubble=1, stall_cnt=1; the following cycle is a RUN-with-no-event cycle.
- STALL_CYCLES=3 with the same hit -> 3 consecutive stall cycles, stall_cnt=1; lu_hit held high during STALL does not extend the stall.
- No false hit: match on rr_src2=3 with rr_use2=0 -> no stall. Load with ex_wr_en=0 and matching dest -> no stall.
- Branch beats stall: lu_hit and ex_br_taken with target 16'h0040 in the same cycle -> redirect_valid=1, redirect_pc=16'h0040, both flushes=1, stall_cnt unchanged, flush_cnt=1. Repeating this during STALL cycle 2 returns the FSM to RUN.
- Saturation, CNT_W=4: 17 separate load-use events -> stall_cnt holds at 4'hF.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: FSM encoding, field widths and the control
// values a pipeline register loads when it is bubbled or flushed.
package hazard_ctrl_pkg;

  localparam int REG_ID_W = 3;
  localparam int PC_W     = 16;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  // Control fields carried by a NOP; bubble/flush force these into a register.
  localparam logic NOP_VALID   = 1'b0;
  localparam logic NOP_WR_EN   = 1'b0;
  localparam logic NOP_IS_LOAD = 1'b0;
  localparam logic NOP_BR      = 1'b0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that saturates at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Count events; clear has priority, value holds once all-ones is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Backward pipeline control: load-use stalls (optionally multi-cycle) and
// taken-branch flush/redirect, with saturating event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rr_valid,
  input  logic [REG_ID_W-1:0] rr_src1,
  input  logic [REG_ID_W-1:0] rr_src2,
  input  logic                rr_use1,
  input  logic                rr_use2,
  input  logic                ex_valid,
  input  logic [REG_ID_W-1:0] ex_dest,
  input  logic                ex_wr_en,
  input  logic                ex_is_load,
  input  logic                ex_br_taken,
  input  logic [PC_W-1:0]     ex_br_target,
  output logic                pc_en,
  output logic                if_id_en,
  output logic                id_rr_en,
  output logic                rr_ex_bubble,
  output logic                flush_if_id,
  output logic                flush_id_rr,
  output logic                redirect_valid,
  output logic [PC_W-1:0]     redirect_pc,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  // Remaining stall cycles loaded when a hazard is seen in RUN.
  localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);

  hz_state_e  state;
  logic [2:0] stall_left;
  logic       lu_hit;
  logic       stall_inc;
  logic       flush_inc;

  // Register 0 gets no special treatment: a match on it is a real hazard.
  assign lu_hit = ex_valid & ex_is_load & ex_wr_en & rr_valid &
                  ((rr_use1 & (rr_src1 == ex_dest)) |
                   (rr_use2 & (rr_src2 == ex_dest)));

  // A stall event is counted only on its first cycle and only if no branch wins.
  assign stall_inc = (state == RUN) & lu_hit & ~ex_br_taken;
  assign flush_inc = ex_br_taken;

  // Mealy control outputs: branch beats stall, reset forces a safe NOP pipeline.
  always_comb begin
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    id_rr_en       = 1'b1;
    rr_ex_bubble   = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_rr    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_rr_en     = 1'b0;
      rr_ex_bubble = 1'b1;
      flush_if_id  = 1'b1;
      flush_id_rr  = 1'b1;
    end else if (ex_br_taken) begin
      // The stalled RR instruction is wrong-path; the flush discards it.
      redirect_valid = 1'b1;
      redirect_pc    = ex_br_target;
      flush_if_id    = 1'b1;
      flush_id_rr    = 1'b1;
      rr_ex_bubble   = 1'b1;
      if_id_en       = 1'b0;
      id_rr_en       = 1'b0;
    end else if ((state == STALL) || lu_hit) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_rr_en     = 1'b0;
      rr_ex_bubble = 1'b1;
    end
  end

  // RUN/STALL sequencing; lu_hit is ignored while already stalling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      stall_left <= '0;
    end else if (ex_br_taken) begin
      state      <= RUN;
      stall_left <= '0;
    end else begin
      case (state)
        RUN: begin
          if (lu_hit && (STALL_CYCLES > 1)) begin
            state      <= STALL;
            stall_left <= STALL_LOAD;
          end
        end
        STALL: begin
          if (stall_left == 3'd1) begin
            state      <= RUN;
            stall_left <= '0;
          end else begin
            stall_left <= stall_left - 3'd1;
          end
        end
        default: begin
          state      <= RUN;
          stall_left <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .clr (1'b0),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .clr (1'b0),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1-cycle stall / 16-bit counters and
// 3-cycle stall / 4-bit counters) share one stimulus stream and are compared
// every cycle against a cycle-count model, plus hand-computed spot checks.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rr_valid, rr_use1, rr_use2;
  logic [2:0]  rr_src1, rr_src2, ex_dest;
  logic        ex_valid, ex_wr_en, ex_is_load, ex_br_taken;
  logic [15:0] ex_br_target;

  logic        a_pc, a_ifid, a_idrr, a_bub, a_fif, a_fid, a_rv;
  logic [15:0] a_rp, a_sc, a_fc;
  logic        b_pc, b_ifid, b_idrr, b_bub, b_fif, b_fid, b_rv;
  logic [15:0] b_rp;
  logic [3:0]  b_sc, b_fc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .rr_valid(rr_valid), .rr_src1(rr_src1), .rr_src2(rr_src2),
    .rr_use1(rr_use1), .rr_use2(rr_use2), .ex_valid(ex_valid), .ex_dest(ex_dest),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .ex_br_target(ex_br_target), .pc_en(a_pc), .if_id_en(a_ifid), .id_rr_en(a_idrr),
    .rr_ex_bubble(a_bub), .flush_if_id(a_fif), .flush_id_rr(a_fid),
    .redirect_valid(a_rv), .redirect_pc(a_rp), .stall_cnt(a_sc), .flush_cnt(a_fc));

  hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .rr_valid(rr_valid), .rr_src1(rr_src1), .rr_src2(rr_src2),
    .rr_use1(rr_use1), .rr_use2(rr_use2), .ex_valid(ex_valid), .ex_dest(ex_dest),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .ex_br_target(ex_br_target), .pc_en(b_pc), .if_id_en(b_ifid), .id_rr_en(b_idrr),
    .rr_ex_bubble(b_bub), .flush_if_id(b_fif), .flush_id_rr(b_fid),
    .redirect_valid(b_rv), .redirect_pc(b_rp), .stall_cnt(b_sc), .flush_cnt(b_fc));

  // Model: stall cycles still owed after the current one, and event counts.
  int stall_len [2] = '{1, 3};
  int cnt_max   [2] = '{65535, 15};
  int owed      [2] = '{0, 0};
  int m_sc      [2] = '{0, 0};
  int m_fc      [2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hit();
    return ex_valid && ex_is_load && ex_wr_en && rr_valid &&
           ((rr_use1 && rr_src1 == ex_dest) || (rr_use2 && rr_src2 == ex_dest));
  endfunction

  task automatic compare_one(input int k, input logic pc, input logic ifid, input logic idrr,
                             input logic bub, input logic fif, input logic fid, input logic rv,
                             input logic [15:0] rp, input logic [31:0] sc, input logic [31:0] fc);
    string p;
    bit stalling;
    p = (k == 0) ? "u_a" : "u_b";
    stalling = (owed[k] > 0) || model_hit();
    chk({p, ".stall_cnt"}, sc, m_sc[k]);
    chk({p, ".flush_cnt"}, fc, m_fc[k]);
    if (rst) begin
      chk({p, ".rst_outs"}, {pc, ifid, idrr, bub, fif, fid, rv}, 7'b0001110);
      chk({p, ".rst_rpc"}, rp, 16'h0000);
    end else if (ex_br_taken) begin
      chk({p, ".br_outs"}, {pc, bub, fif, fid, rv}, 5'b11111);
      chk({p, ".br_rpc"}, rp, ex_br_target);
    end else begin
      chk({p, ".enables"}, {pc, ifid, idrr}, stalling ? 3'b000 : 3'b111);
      chk({p, ".bubble"}, bub, stalling);
      chk({p, ".flush_redir"}, {fif, fid, rv}, 3'b000);
      chk({p, ".rpc_known"}, {15'd0, ^rp === 1'bx}, 0);
    end
  endtask

  task automatic advance_one(input int k);
    if (ex_br_taken) begin
      owed[k] = 0;
      if (m_fc[k] < cnt_max[k]) m_fc[k]++;
    end else if (owed[k] > 0) begin
      owed[k]--;
    end else if (model_hit()) begin
      owed[k] = stall_len[k] - 1;
      if (m_sc[k] < cnt_max[k]) m_sc[k]++;
    end
  endtask

  // Compare mid-cycle, then step the model to what the next posedge will do.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        owed[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end
    end
    compare_one(0, a_pc, a_ifid, a_idrr, a_bub, a_fif, a_fid, a_rv, a_rp, 32'(a_sc), 32'(a_fc));
    compare_one(1, b_pc, b_ifid, b_idrr, b_bub, b_fif, b_fid, b_rv, b_rp, 32'(b_sc), 32'(b_fc));
    if (!rst) begin
      advance_one(0);
      advance_one(1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rr_valid = 1'b0; rr_src1 = 3'd0; rr_src2 = 3'd0; rr_use1 = 1'b0; rr_use2 = 1'b0;
    ex_valid = 1'b0; ex_dest = 3'd0; ex_wr_en = 1'b0; ex_is_load = 1'b0;
    ex_br_taken = 1'b0; ex_br_target = 16'h0000;
  endtask

  task automatic hit();
    idle();
    rr_valid = 1'b1; rr_src1 = 3'd3; rr_use1 = 1'b1;
    ex_valid = 1'b1; ex_dest = 3'd3; ex_wr_en = 1'b1; ex_is_load = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #7;
    chk("lit.rst_pc_en", a_pc, 1'b0);
    chk("lit.rst_bubble_flush", {b_bub, b_fif, b_fid}, 3'b111);
    chk("lit.rst_cnt", b_sc, 4'h0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("lit.run_pc_en", {a_pc, b_pc}, 2'b11);

    // Single load-use hit
    hit();
    #1;
    chk("lit.hit_a", {a_pc, a_bub}, 2'b01);
    cyc();
    idle();
    #1;
    chk("lit.hit_a_cnt", a_sc, 16'd1);
    chk("lit.hit_a_after", {a_pc, a_bub}, 2'b10);
    chk("lit.hit_b_stall2", {b_pc, b_bub}, 2'b01);
    repeat (3) cyc();

    // Hit held high for 3 cycles: u_b stalls once, u_a restalls every cycle
    hit();
    repeat (3) cyc();
    idle();
    #1;
    chk("lit.hold_b_cnt", b_sc, 4'd2);
    chk("lit.hold_b_run", b_pc, 1'b1);
    chk("lit.hold_a_cnt", a_sc, 16'd4);
    cyc();

    // No false hits
    hit(); rr_src1 = 3'd5; rr_src2 = 3'd3; rr_use2 = 1'b0;
    #1;
    chk("lit.nohit_use2", {a_pc, b_pc}, 2'b11);
    cyc();
    hit(); ex_wr_en = 1'b0;
    #1;
    chk("lit.nohit_wren", {a_pc, b_pc}, 2'b11);
    cyc();
    hit(); ex_valid = 1'b0; cyc();
    hit(); rr_valid = 1'b0; cyc();
    hit(); ex_is_load = 1'b0; cyc();
    // Register 0 on source 2 is still a hazard
    hit(); ex_dest = 3'd0; rr_src1 = 3'd1; rr_src2 = 3'd0; rr_use2 = 1'b1; cyc();
    idle(); repeat (3) cyc();

    // Branch beats stall
    hit(); ex_br_taken = 1'b1; ex_br_target = 16'h0040;
    #1;
    chk("lit.br_rv_rpc", {a_rv, a_rp}, {1'b1, 16'h0040});
    chk("lit.br_flush", {a_fif, a_fid, a_bub, a_pc}, 4'b1111);
    cyc();
    idle();
    #1;
    chk("lit.br_a_cnts", {a_sc, a_fc}, {16'd5, 16'd1});
    cyc();

    // Branch during STALL cycle 2 returns u_b to RUN
    hit(); cyc();
    idle(); ex_br_taken = 1'b1; ex_br_target = 16'h1234; cyc();
    idle();
    #1;
    chk("lit.br_in_stall", {b_pc, b_bub}, 2'b10);
    cyc();

    // Reset during STALL cycle 2
    hit(); cyc();
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("lit.midrst_cnt", {b_sc, b_fc}, 8'h00);
    cyc();
    rst = 1'b0;
    #1;
    chk("lit.midrst_run", {b_pc, b_bub}, 2'b10);
    cyc();

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 17; i++) begin
      hit(); cyc();
      idle(); cyc(); cyc();
    end
    chk("lit.sat_stall", b_sc, 4'hF);
    chk("lit.sat_stall_a", a_sc, 16'd17);
    idle(); ex_br_taken = 1'b1; ex_br_target = 16'hBEEF;
    repeat (17) cyc();
    idle();
    cyc();
    chk("lit.sat_flush", b_fc, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
